loader_bus_arbiter: RTL and testbench
=====================================

// Module: loader_bus_arbiter
// PURPOSE
//  Shares the single-port system RAM between the Z80 CPU and the file/erase loader.
//  Loader writes are queued in a small FIFO, and the CPU bus is taken with BUSRQ/BUSAK
//  before any queued write reaches RAM.
//  After a download ends, any latched execute request is applied by a REGSET pulse to the CPU,
//  then the bus is returned to the CPU. Sits between the loader, the CPU core and the RAM wrapper.
// PARAMETERS
//  DATA        8   data bus width
//  ADDR        16  address bus width
//  FIFO_DEPTH  4   loader write FIFO entries (power of two, >=2)
//  REGSET_CYC  4   cycles cpu_regset is held high
// PORTS
//  clock           in   1     system clock
//  reset_n         in   1     asynchronous reset, active low
//  ld_download     in   1     loader download/erase active
//  ld_wr           in   1     loader write strobe (1 cycle per byte)
//  ld_addr         in   ADDR  loader write address
//  ld_data         in   DATA  loader write data
//  ld_exec_en      in   1     loader execute request (level)
//  ld_exec_addr    in   ADDR  execute start address
//  ld_full         out  1     FIFO almost full; drives the upstream ioctl_wait
//  ld_overflow     out  1     sticky: a write was dropped while the FIFO was full
//  cpu_addr        in   ADDR  CPU address
//  cpu_dout        in   DATA  CPU write data
//  cpu_we          in   1     CPU RAM write enable
//  cpu_busak       in   1     CPU bus acknowledge, active high
//  cpu_busrq       out  1     bus request to CPU, active high
//  cpu_regset      out  1     load PC from cpu_pc
//  cpu_pc          out  ADDR  start address for REGSET
//  ram_addr        out  ADDR  RAM address
//  ram_din         out  DATA  RAM write data
//  ram_we          out  1     RAM write enable
//  busy            out  1     state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; FIFO empty; cpu_busrq=0, cpu_regset=0, cpu_pc=0, ld_overflow=0.
//   ld_full=0, ram_we=0, busy=0.
//  Ownership:
//   - When owner=CPU, ram_addr/ram_din/ram_we = cpu_addr/cpu_dout/cpu_we, combinational.
//   - When owner=LOADER, the RAM port is driven from registers loaded on each FIFO pop.
//     ram_we=1 for exactly one cycle per pop.
//   - Owner switches to LOADER only in a cycle with cpu_busak=1, and back to CPU only
//     on the IDLE transition.
//  FIFO:
//   - Push on ld_wr in every state; pop only in LOAD/DRAIN.
//   - Pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2+1 bits.
//   - Push and pop in the same cycle: count unchanged.
//   - Push while count==FIFO_DEPTH: write dropped, ld_overflow set until reset.
//   - ld_full = (count >= FIFO_DEPTH-1), registered, so one in-flight write is absorbed.
//  Exec latch:
//   - A rising edge of ld_exec_en captures ld_exec_addr and sets exec_pend.
//   - A later edge overwrites the captured address.
//   - exec_pend is cleared on entry to EXEC.
//  FSM:
//   IDLE    : ld_download=1 or FIFO non-empty -> REQ; cpu_busrq<=1.
//   REQ     : cpu_busak=1 -> LOAD (owner=LOADER). Waits indefinitely; pushes still accepted.
//   LOAD    : pop 1 entry/cycle when non-empty.
//             ld_download=0 -> DRAIN.
//   DRAIN   : pop until empty, then go to EXEC if exec_pend, else to REL.
//             If ld_download rises again -> LOAD.
//   EXEC    : cpu_pc<=latched addr; cpu_regset=1 for REGSET_CYC cycles -> REL.
//   REL     : cpu_busrq<=0, owner=CPU -> IDLE once cpu_busak=0.
//  Latency:
//   - ld_wr to ram_we is 2 cycles min once LOAD is reached (push, then registered pop).
//   - cpu_busak loss during LOAD/DRAIN is treated as a protocol error: hold pops until
//     cpu_busak returns.
//  Reset mid-operation: everything returns to reset values immediately, and queued writes
//   are discarded. cpu_busrq drops asynchronously.
// TESTING
//  1. busak 3 cycles after busrq; 5 writes to 4000..4004 data 11..15; download drop
//     -> RAM holds 11..15, cpu_busrq low after busak low, no regset.
//  2. ld_exec_en rises with 5200 during a download -> after drain, cpu_regset high 4 cycles
//     with cpu_pc=5200, then bus released.
//  3. Writes every cycle with busak delayed 10 cycles -> ld_full at count 3.
//     5th write while count=4 is dropped and ld_overflow=1.
//  4. Push+pop in the same cycle at count 2 -> count stays 2, data order preserved across
//     pointer wrap (9 writes).
//  5. reset_n low during LOAD with 2 queued -> cpu_busrq=0, ram_we=0, FIFO empty,
//     state IDLE next cycle.
//  6. IDLE CPU write to 8000 data A5 -> ram_we/addr/din follow CPU combinationally,
//     busy=0.

Source files
------------

// File: rtl/loader_bus_arbiter.sv
// Arbitrates the single-port system RAM between the Z80 CPU and the loader.
// Loader writes are queued and drained under BUSRQ/BUSAK, with an optional REGSET on exit.
module loader_bus_arbiter #(
    parameter int DATA       = 8,
    parameter int ADDR       = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int REGSET_CYC = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            ld_download,
    input  logic            ld_wr,
    input  logic [ADDR-1:0] ld_addr,
    input  logic [DATA-1:0] ld_data,
    input  logic            ld_exec_en,
    input  logic [ADDR-1:0] ld_exec_addr,
    output logic            ld_full,
    output logic            ld_overflow,
    input  logic [ADDR-1:0] cpu_addr,
    input  logic [DATA-1:0] cpu_dout,
    input  logic            cpu_we,
    input  logic            cpu_busak,
    output logic            cpu_busrq,
    output logic            cpu_regset,
    output logic [ADDR-1:0] cpu_pc,
    output logic [ADDR-1:0] ram_addr,
    output logic [DATA-1:0] ram_din,
    output logic            ram_we,
    output logic            busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(REGSET_CYC + 1);
    localparam logic [PW:0] C_DEPTH = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0] C_FULL_TH = (PW+1)'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] C_RS_LAST = CW'(REGSET_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LOAD,
        S_DRAIN,
        S_EXEC,
        S_REL
    } state_t;

    state_t r_state;

    logic [ADDR+DATA-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wptr;
    logic [PW-1:0]        r_rptr;
    logic [PW:0]          r_count;
    logic                 r_full;
    logic                 r_ovf;

    logic                 r_owner_ld;
    logic [ADDR-1:0]      r_ld_addr;
    logic [DATA-1:0]      r_ld_data;
    logic                 r_ld_we;

    logic                 r_busrq;
    logic                 r_regset;
    logic [ADDR-1:0]      r_pc;
    logic [CW-1:0]        r_rs_cnt;

    logic                 r_exec_d;
    logic                 r_exec_pend;
    logic [ADDR-1:0]      r_exec_addr;

    logic                 w_empty;
    logic                 w_fifo_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_exec_rise;
    logic [PW:0]          w_count_nxt;
    logic [ADDR+DATA-1:0] w_rd;

    assign w_empty     = (r_count == '0);
    assign w_fifo_full = (r_count == C_DEPTH);
    assign w_push      = ld_wr & ~w_fifo_full;
    // Pops stall if the CPU lets go of the bus mid-transfer.
    assign w_pop       = ((r_state == S_LOAD) || (r_state == S_DRAIN))
                         & cpu_busak & ~w_empty;
    assign w_exec_rise = ld_exec_en & ~r_exec_d;
    assign w_rd        = r_mem[r_rptr];

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr] <= {ld_addr, ld_data};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt >= C_FULL_TH);
            if (ld_wr && w_fifo_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_owner_ld  <= 1'b0;
            r_ld_addr   <= '0;
            r_ld_data   <= '0;
            r_ld_we     <= 1'b0;
            r_busrq     <= 1'b0;
            r_regset    <= 1'b0;
            r_pc        <= '0;
            r_rs_cnt    <= '0;
            r_exec_d    <= 1'b0;
            r_exec_pend <= 1'b0;
            r_exec_addr <= '0;
        end else begin
            r_exec_d <= ld_exec_en;
            r_ld_we  <= w_pop;
            if (w_pop) begin
                {r_ld_addr, r_ld_data} <= w_rd;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (ld_download || !w_empty) begin
                        r_state <= S_REQ;
                        r_busrq <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (cpu_busak) begin
                        r_state    <= S_LOAD;
                        r_owner_ld <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (!ld_download) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (ld_download) begin
                        r_state <= S_LOAD;
                    end else if (w_empty) begin
                        if (r_exec_pend) begin
                            r_state     <= S_EXEC;
                            r_pc        <= r_exec_addr;
                            r_regset    <= 1'b1;
                            r_rs_cnt    <= '0;
                            r_exec_pend <= 1'b0;
                        end else begin
                            r_state <= S_REL;
                            r_busrq <= 1'b0;
                        end
                    end
                end
                S_EXEC: begin
                    if (r_rs_cnt == C_RS_LAST) begin
                        r_state  <= S_REL;
                        r_regset <= 1'b0;
                        r_busrq  <= 1'b0;
                    end else begin
                        r_rs_cnt <= r_rs_cnt + 1'b1;
                    end
                end
                S_REL: begin
                    if (!cpu_busak) begin
                        r_state    <= S_IDLE;
                        r_owner_ld <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // A fresh request arriving alongside EXEC entry must not be lost.
            if (w_exec_rise) begin
                r_exec_addr <= ld_exec_addr;
                r_exec_pend <= 1'b1;
            end
        end
    end

    assign ld_full     = r_full;
    assign ld_overflow = r_ovf;
    assign cpu_busrq   = r_busrq;
    assign cpu_regset  = r_regset;
    assign cpu_pc      = r_pc;
    assign busy        = (r_state != S_IDLE);
    assign ram_addr    = r_owner_ld ? r_ld_addr : cpu_addr;
    assign ram_din     = r_owner_ld ? r_ld_data : cpu_dout;
    assign ram_we      = r_owner_ld ? r_ld_we : cpu_we;

endmodule

// File: tb/tb_loader_bus_arbiter.sv
// Scoreboard bench for loader_bus_arbiter: expected RAM writes and REGSET
// events are queued by the stimulus and retired by independent monitors.
module tb_loader_bus_arbiter;

    logic        clock;
    logic        reset_n;
    logic        ld_download;
    logic        ld_wr;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_exec_en;
    logic [15:0] ld_exec_addr;
    logic        ld_full;
    logic        ld_overflow;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_we;
    logic        cpu_busak;
    logic        cpu_busrq;
    logic        cpu_regset;
    logic [15:0] cpu_pc;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic        busy;

    loader_bus_arbiter dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .ld_download  (ld_download),
        .ld_wr        (ld_wr),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .ld_exec_en   (ld_exec_en),
        .ld_exec_addr (ld_exec_addr),
        .ld_full      (ld_full),
        .ld_overflow  (ld_overflow),
        .cpu_addr     (cpu_addr),
        .cpu_dout     (cpu_dout),
        .cpu_we       (cpu_we),
        .cpu_busak    (cpu_busak),
        .cpu_busrq    (cpu_busrq),
        .cpu_regset   (cpu_regset),
        .cpu_pc       (cpu_pc),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_we       (ram_we),
        .busy         (busy)
    );

    int errors = 0;
    int checks = 0;
    logic [23:0] exp_q [$];
    logic [15:0] exec_q [$];
    int busak_dly = 3;
    int rs_events = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d,
                      input bit expect_it);
        if (expect_it) exp_q.push_back({a, d});
        ld_wr   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_wr   = 1'b0;
    endtask

    task automatic wait_busak();
        int n = 0;
        while (!cpu_busak && n < 100) begin
            tick();
            n++;
        end
        chk("busak_timeout", 32'(cpu_busak), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Behavioural CPU: grants the bus busak_dly cycles after a request.
    initial begin
        int cnt = 0;
        cpu_busak = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            if (cpu_busrq) begin
                if (!cpu_busak) begin
                    if (cnt >= busak_dly) cpu_busak = 1'b1;
                    else cnt++;
                end
            end else begin
                cpu_busak = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin
        logic [23:0] e;
        logic [15:0] p;
        bit rs_prev = 1'b0;
        int rs_w = 0;
        forever begin
            @(negedge clock);
            if (reset_n && ram_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {8'h0, ram_addr, ram_din}, 32'hffffffff);
                end else begin
                    e = exp_q.pop_front();
                    chk("ram_write", {8'h0, ram_addr, ram_din}, {8'h0, e});
                end
            end
            if (cpu_regset && !rs_prev) begin
                rs_events++;
                rs_w = 0;
                if (exec_q.size() == 0) begin
                    chk("unexpected_regset", {16'h0, cpu_pc}, 32'hffffffff);
                end else begin
                    p = exec_q.pop_front();
                    chk("regset_pc", {16'h0, cpu_pc}, {16'h0, p});
                end
            end
            if (cpu_regset) rs_w++;
            if (!cpu_regset && rs_prev) chk("regset_width", rs_w, 4);
            rs_prev = cpu_regset;
        end
    end

    initial begin
        reset_n      = 1'b0;
        ld_download  = 1'b0;
        ld_wr        = 1'b0;
        ld_addr      = '0;
        ld_data      = '0;
        ld_exec_en   = 1'b0;
        ld_exec_addr = '0;
        cpu_addr     = '0;
        cpu_dout     = '0;
        cpu_we       = 1'b0;
        tick(3);
        chk("rst_busrq", 32'(cpu_busrq), 0);
        chk("rst_regset", 32'(cpu_regset), 0);
        chk("rst_pc", 32'(cpu_pc), 0);
        chk("rst_full", 32'(ld_full), 0);
        chk("rst_ovf", 32'(ld_overflow), 0);
        chk("rst_we", 32'(ram_we), 0);
        chk("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        tick(2);

        // Plain download of five bytes, no exec request.
        busak_dly = 3;
        ld_download = 1'b1;
        wait_busak();
        tick();
        for (int i = 0; i < 5; i++)
            wr(16'h4000 + 16'(i), 8'h11 + 8'(i), 1'b1);
        ld_download = 1'b0;
        wait_idle();
        chk("t1_busrq", 32'(cpu_busrq), 0);
        chk("t1_busak", 32'(cpu_busak), 0);
        chk("t1_drained", exp_q.size(), 0);
        chk("t1_no_regset", rs_events, 0);

        // Exec request during download; a second edge overwrites the address.
        ld_download = 1'b1;
        wait_busak();
        tick();
        wr(16'h6000, 8'h21, 1'b1);
        ld_exec_addr = 16'h5100;
        ld_exec_en   = 1'b1;
        tick(2);
        ld_exec_en   = 1'b0;
        wr(16'h6001, 8'h22, 1'b1);
        ld_exec_addr = 16'h5200;
        ld_exec_en   = 1'b1;
        exec_q.push_back(16'h5200);
        tick(2);
        ld_exec_en   = 1'b0;
        ld_download  = 1'b0;
        wait_idle();
        tick(2);
        chk("t2_regset_cnt", rs_events, 1);
        chk("t2_busrq", 32'(cpu_busrq), 0);
        chk("t2_drained", exp_q.size(), 0);

        // CPU owns RAM in IDLE: combinational passthrough.
        exp_q.push_back({16'h8000, 8'ha5});
        cpu_addr = 16'h8000;
        cpu_dout = 8'ha5;
        cpu_we   = 1'b1;
        #1;
        chk("t6_we", 32'(ram_we), 1);
        chk("t6_addr", 32'(ram_addr), 32'h8000);
        chk("t6_din", 32'(ram_din), 32'ha5);
        chk("t6_busy", 32'(busy), 0);
        tick();
        cpu_we = 1'b0;
        tick();

        // Steady push+pop at count 2 across pointer wrap.
        busak_dly = 6;
        ld_download = 1'b1;
        wr(16'h3000, 8'h40, 1'b1);
        wr(16'h3001, 8'h41, 1'b1);
        wait_busak();
        tick();
        for (int i = 2; i < 9; i++) begin
            wr(16'h3000 + 16'(i), 8'h40 + 8'(i), 1'b1);
            chk("t4_full", 32'(ld_full), 0);
        end
        ld_download = 1'b0;
        wait_idle();
        chk("t4_drained", exp_q.size(), 0);
        chk("t4_ovf", 32'(ld_overflow), 0);

        // Back-to-back writes with a slow grant: almost-full then overflow.
        busak_dly = 10;
        ld_download = 1'b1;
        wr(16'h7000, 8'h31, 1'b1);
        chk("t3_full1", 32'(ld_full), 0);
        wr(16'h7001, 8'h32, 1'b1);
        chk("t3_full2", 32'(ld_full), 0);
        wr(16'h7002, 8'h33, 1'b1);
        chk("t3_full3", 32'(ld_full), 1);
        wr(16'h7003, 8'h34, 1'b1);
        chk("t3_full4", 32'(ld_full), 1);
        chk("t3_ovf_before", 32'(ld_overflow), 0);
        wr(16'h7004, 8'h35, 1'b0);
        chk("t3_ovf_after", 32'(ld_overflow), 1);
        wait_busak();
        ld_download = 1'b0;
        wait_idle();
        chk("t3_drained", exp_q.size(), 0);
        chk("t3_full_clear", 32'(ld_full), 0);
        chk("t3_ovf_sticky", 32'(ld_overflow), 1);

        // Reset while two writes are still queued in LOAD.
        busak_dly = 4;
        ld_download = 1'b1;
        wr(16'h9000, 8'h51, 1'b0);
        wr(16'h9001, 8'h52, 1'b0);
        wait_busak();
        tick();
        reset_n = 1'b0;
        ld_download = 1'b0;
        #1;
        chk("t5_busrq", 32'(cpu_busrq), 0);
        chk("t5_we", 32'(ram_we), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_ovf", 32'(ld_overflow), 0);
        chk("t5_full", 32'(ld_full), 0);
        tick();
        reset_n = 1'b1;
        tick(4);
        chk("t5_fifo_empty", 32'(busy), 0);
        chk("t5_no_busrq", 32'(cpu_busrq), 0);

        tick(3);
        chk("final_wr_q", exp_q.size(), 0);
        chk("final_exec_q", exec_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
